mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester round-robin arbiter in front of a single
//               cache-line memory port. Registered grant, abort on dropped
//               request, per-transaction timeout with sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_rw,
    input  logic              r0_valid,
    output logic              r0_ready,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_rw,
    input  logic              r1_valid,
    output logic              r1_ready,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    output logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              err_timeout
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GRANT0 = 2'd1;
    localparam logic [1:0] c_GRANT1 = 2'd2;
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_owner;   // 0 = r0 finished last, 1 = r1 finished last
    logic [7:0] r_cnt;
    logic       r_err;

    logic w_busy;
    logic w_sel_valid;
    logic w_done;
    logic w_tmo;
    logic w_abort;

    // Transaction end conditions; a real completion takes precedence over
    // both abort and timeout when they coincide.
    always_comb begin
        w_busy      = (r_state != c_IDLE);
        w_sel_valid = (r_state == c_GRANT0) ? r0_valid :
                      (r_state == c_GRANT1) ? r1_valid : 1'b0;
        w_done      = w_busy & mem_ready;
        w_tmo       = w_busy & w_sel_valid & ~mem_ready & (r_cnt == c_TO_LAST);
        w_abort     = w_busy & ~w_sel_valid & ~mem_ready;
    end

    // State register, owner history, cycle counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_last_owner <= 1'b1;
            r_cnt        <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_done || w_tmo)
                r_last_owner <= (r_state == c_GRANT1);
            if (w_tmo)
                r_err <= 1'b1;
            // Counter sits at zero while idle so every grant starts from zero
            if (w_busy && (w_next_state == r_state))
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= 8'd0;
        end
    end

    // Next-state: round-robin on ties, back to IDLE on any transaction end
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (r0_valid && r1_valid)
                    w_next_state = r_last_owner ? c_GRANT0 : c_GRANT1;
                else if (r0_valid)
                    w_next_state = c_GRANT0;
                else if (r1_valid)
                    w_next_state = c_GRANT1;
            end
            c_GRANT0, c_GRANT1: begin
                if (w_done || w_tmo || w_abort)
                    w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs: memory mux from the owner, completion/timeout pulse back to it
    always_comb begin
        grant     = {(r_state == c_GRANT1), (r_state == c_GRANT0)};
        mem_valid = w_busy;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rw    = 1'b0;
        if (grant[0]) begin
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            mem_rw    = r0_rw;
        end else if (grant[1]) begin
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            mem_rw    = r1_rw;
        end
        r0_ready    = grant[0] & (mem_ready | w_tmo);
        r1_ready    = grant[1] & (mem_ready | w_tmo);
        r0_rdata    = (grant[0] & mem_ready) ? mem_rdata : '0;
        r1_rdata    = (grant[1] & mem_ready) ? mem_rdata : '0;
        err_timeout = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, table-driven self-checking bench for
//               mem_port_arbiter plus multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_AW = 32;
    localparam int c_DW = 128;
    localparam int c_TO = 8;
    localparam logic [c_DW-1:0] c_R0WD = 128'h1111;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [c_AW-1:0] r0_addr = '0, r1_addr = '0, mem_addr;
    logic [c_DW-1:0] r0_wdata = c_R0WD, r1_wdata = '0, mem_wdata, mem_rdata = '0;
    logic [c_DW-1:0] r0_rdata, r1_rdata;
    logic            r0_rw = 0, r1_rw = 0, r0_valid = 0, r1_valid = 0;
    logic            r0_ready, r1_ready, mem_rw, mem_valid, mem_ready = 0, err_timeout;
    logic [1:0]      grant;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .TIMEOUT_CYC(c_TO)) dut (
        .clk(clk), .rst(rst),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rw(r0_rw), .r0_valid(r0_valid),
        .r0_ready(r0_ready), .r0_rdata(r0_rdata),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rw(r1_rw), .r1_valid(r1_valid),
        .r1_ready(r1_ready), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            r0v;  logic [c_AW-1:0] r0a; logic r0rw;
        logic            r1v;  logic [c_AW-1:0] r1a; logic r1rw; logic [c_DW-1:0] r1wd;
        logic            mr;   logic [c_DW-1:0] mrd;
        logic [1:0]      gnt;  logic mv; logic [c_AW-1:0] ma; logic mrw; logic [c_DW-1:0] mwd;
        logic            rdy0; logic rdy1; logic [c_DW-1:0] rd0; logic [c_DW-1:0] rd1;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r0v, input logic [c_AW-1:0] r0a, input logic r1v, input logic mr,
        input logic [c_DW-1:0] mrd, input logic [1:0] gnt, input logic rdy0, input logic rdy1);
        vec_t v;
        v.r0v = r0v; v.r0a = r0a; v.r0rw = 1'b0;
        v.r1v = r1v; v.r1a = 32'hEB00; v.r1rw = 1'b1; v.r1wd = 128'h5566;
        v.mr = mr; v.mrd = mrd; v.gnt = gnt; v.mv = (gnt != 2'b00);
        v.ma  = gnt[0] ? r0a : gnt[1] ? 32'hEB00 : '0;
        v.mrw = gnt[1];
        v.mwd = gnt[0] ? c_R0WD : gnt[1] ? 128'h5566 : '0;
        v.rdy0 = rdy0; v.rdy1 = rdy1;
        v.rd0 = rdy0 ? mrd : '0;
        v.rd1 = rdy1 ? mrd : '0;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        r0_valid = 0; r1_valid = 0; mem_ready = 0; r0_rw = 0; r1_rw = 0;
        r0_addr = '0; r1_addr = '0; r1_wdata = '0; mem_rdata = '0;
        @(negedge clk);
        #1;
        chk("rst_grant", 128'(grant), 128'(2'b00));
        chk("rst_mem_valid", 128'(mem_valid), 128'(1'b0));
        chk("rst_err", 128'(err_timeout), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [1:0] exp_g[10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic       sch_mr[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

    initial begin
        tbl[0]  = mk(1, 32'hAB00, 0, 1, 128'hA1, 2'b00, 0, 0);
        tbl[1]  = mk(1, 32'hAB00, 0, 1, 128'hA1, 2'b01, 1, 0);
        tbl[2]  = mk(0, 32'hAB00, 0, 1, 128'hA1, 2'b00, 0, 0);
        tbl[3]  = mk(1, 32'hA000, 1, 0, 128'hB2, 2'b00, 0, 0);
        tbl[4]  = mk(1, 32'hA000, 1, 0, 128'hB2, 2'b10, 0, 0);
        tbl[5]  = mk(1, 32'hA000, 1, 1, 128'hB2, 2'b10, 0, 1);
        tbl[6]  = mk(1, 32'hA000, 0, 1, 128'hB2, 2'b00, 0, 0);
        tbl[7]  = mk(1, 32'hA000, 0, 0, 128'hB2, 2'b01, 0, 0);
        tbl[8]  = mk(0, 32'hA000, 0, 0, 128'hB2, 2'b01, 0, 0);
        tbl[9]  = mk(0, 32'hA000, 0, 0, 128'hB2, 2'b00, 0, 0);
        tbl[10] = mk(1, 32'hA000, 1, 0, 128'hC3, 2'b00, 0, 0);
        tbl[11] = mk(1, 32'hA000, 1, 0, 128'hC3, 2'b01, 0, 0);
        tbl[12] = mk(1, 32'hA000, 1, 1, 128'hC3, 2'b01, 1, 0);
        tbl[13] = mk(0, 32'hA000, 1, 1, 128'hC3, 2'b00, 0, 0);
        tbl[14] = mk(0, 32'hA000, 1, 0, 128'hC3, 2'b10, 0, 0);

        // Table: single read, write vs pending read, abort, round-robin
        do_reset();
        for (int i = 0; i < 15; i++) begin
            r0_valid = tbl[i].r0v; r0_addr = tbl[i].r0a; r0_rw = tbl[i].r0rw;
            r1_valid = tbl[i].r1v; r1_addr = tbl[i].r1a; r1_rw = tbl[i].r1rw;
            r1_wdata = tbl[i].r1wd; mem_ready = tbl[i].mr; mem_rdata = tbl[i].mrd;
            #1;
            chk($sformatf("v%0d_grant", i), 128'(grant), 128'(tbl[i].gnt));
            chk($sformatf("v%0d_mem_valid", i), 128'(mem_valid), 128'(tbl[i].mv));
            chk($sformatf("v%0d_mem_addr", i), 128'(mem_addr), 128'(tbl[i].ma));
            chk($sformatf("v%0d_mem_rw", i), 128'(mem_rw), 128'(tbl[i].mrw));
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].mwd);
            chk($sformatf("v%0d_r0_ready", i), 128'(r0_ready), 128'(tbl[i].rdy0));
            chk($sformatf("v%0d_r1_ready", i), 128'(r1_ready), 128'(tbl[i].rdy1));
            chk($sformatf("v%0d_r0_rdata", i), r0_rdata, tbl[i].rd0);
            chk($sformatf("v%0d_r1_rdata", i), r1_rdata, tbl[i].rd1);
            @(negedge clk);
        end

        // Simultaneous requests from reset, memory answers on third grant cycle
        do_reset();
        r0_addr = 32'hA000; r1_addr = 32'hBB00; r1_rw = 0;
        for (int i = 0; i < 10; i++) begin
            r0_valid = 1; r1_valid = 1; mem_ready = sch_mr[i]; mem_rdata = 128'(i + 'h50);
            #1;
            chk($sformatf("rr%0d_grant", i), 128'(grant), 128'(exp_g[i]));
            chk($sformatf("rr%0d_mem_addr", i), 128'(mem_addr),
                exp_g[i][0] ? 128'(32'hA000) : exp_g[i][1] ? 128'(32'hBB00) : 128'd0);
            chk($sformatf("rr%0d_r0_ready", i), 128'(r0_ready), 128'(exp_g[i][0] & sch_mr[i]));
            chk($sformatf("rr%0d_r1_ready", i), 128'(r1_ready), 128'(exp_g[i][1] & sch_mr[i]));
            @(negedge clk);
        end

        // Timeout: memory never answers
        do_reset();
        r0_valid = 1; r0_addr = 32'hC000; mem_ready = 0; mem_rdata = 128'hDEAD;
        @(negedge clk);
        for (int i = 0; i < c_TO; i++) begin
            #1;
            chk($sformatf("to%0d_grant", i), 128'(grant), 128'(2'b01));
            chk($sformatf("to%0d_r0_ready", i), 128'(r0_ready), 128'(i == c_TO - 1));
            chk($sformatf("to%0d_r0_rdata", i), r0_rdata, 128'd0);
            chk($sformatf("to%0d_err", i), 128'(err_timeout), 128'(1'b0));
            @(negedge clk);
        end
        r0_valid = 0; r1_valid = 1; r1_addr = 32'hD000; mem_ready = 1; mem_rdata = 128'hBEEF;
        #1;
        chk("to_after_grant", 128'(grant), 128'(2'b00));
        chk("to_after_err", 128'(err_timeout), 128'(1'b1));
        @(negedge clk);
        #1;
        chk("to_next_grant", 128'(grant), 128'(2'b10));
        chk("to_next_r1_ready", 128'(r1_ready), 128'(1'b1));
        chk("to_next_r1_rdata", r1_rdata, 128'hBEEF);
        chk("to_sticky_err", 128'(err_timeout), 128'(1'b1));
        @(negedge clk);

        // Reset in the middle of a grant
        r1_valid = 0; r0_valid = 1; r0_addr = 32'hE000; mem_ready = 0;
        @(negedge clk);
        #1;
        chk("mr_pre_grant", 128'(grant), 128'(2'b01));
        chk("mr_pre_err", 128'(err_timeout), 128'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("mr_mem_valid", 128'(mem_valid), 128'(1'b0));
        chk("mr_grant", 128'(grant), 128'(2'b00));
        chk("mr_err", 128'(err_timeout), 128'(1'b0));
        mem_ready = 1;
        #1;
        chk("mr_r0_ready", 128'(r0_ready), 128'(1'b0));
        mem_ready = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_rel_grant", 128'(grant), 128'(2'b00));
        @(negedge clk);
        #1;
        chk("mr_regrant", 128'(grant), 128'(2'b01));
        chk("mr_regrant_addr", 128'(mem_addr), 128'(32'hE000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
